// File: rtl/mips_mc_ctrl_if.sv
// Control bus between the multi-cycle MIPS controller and its datapath/memory.
// The controller is the master; datapath-side logic attaches through the slave modport.
interface mips_mc_ctrl_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       bcond;
   logic       mem_ready;
   logic [2:0] aluop;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic       iord;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       pc_write;
   logic [1:0] pc_src;
   logic       reg_write;
   logic       reg_dst;
   logic       mem_to_reg;

   modport master (
      input  opcode, funct, bcond, mem_ready,
      output aluop, alu_src_a, alu_src_b, iord, mem_read, mem_write, ir_write, pc_write,
             pc_src, reg_write, reg_dst, mem_to_reg
   );

   modport slave (
      output opcode, funct, bcond, mem_ready,
      input  aluop, alu_src_a, alu_src_b, iord, mem_read, mem_write, ir_write, pc_write,
             pc_src, reg_write, reg_dst, mem_to_reg
   );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM: Moore decode of state drives ALU selects and datapath
// strobes; counts retired instructions.
module mips_mc_ctrl #(
   parameter int unsigned RETIRE_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   mips_mc_ctrl_if.master      bus,
   output logic                illegal,
   output logic [3:0]          state,
   output logic [RETIRE_W-1:0] retired
);

   typedef enum logic [3:0] {
      StFetch   = 4'd0,
      StDecode  = 4'd1,
      StMemAdr  = 4'd2,
      StMemRd   = 4'd3,
      StMemWb   = 4'd4,
      StMemWr   = 4'd5,
      StRtExe   = 4'd6,
      StRtWb    = 4'd7,
      StBeq     = 4'd8,
      StAddiExe = 4'd9,
      StAddiWb  = 4'd10,
      StJump    = 4'd11
   } state_t;

   state_t              state_q, state_d;
   logic [RETIRE_W-1:0] retired_q;
   logic                retire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StFetch;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         if (retire) retired_q <= retired_q + RETIRE_W'(1);
      end
   end

   always_comb begin
      state_d        = state_q;
      retire         = 1'b0;
      illegal        = 1'b0;
      bus.aluop      = 3'b000;
      bus.alu_src_a  = 1'b0;
      bus.alu_src_b  = 2'b00;
      bus.iord       = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.ir_write   = 1'b0;
      bus.pc_write   = 1'b0;
      bus.pc_src     = 2'b00;
      bus.reg_write  = 1'b0;
      bus.reg_dst    = 1'b0;
      bus.mem_to_reg = 1'b0;

      case (state_q)
         StFetch: begin
            bus.mem_read  = 1'b1;
            bus.alu_src_b = 2'b01;
            // Reset holds state at FETCH; keep the write strobes quiet until release.
            bus.ir_write  = bus.mem_ready & rst_n;
            bus.pc_write  = bus.mem_ready & rst_n;
            if (bus.mem_ready) state_d = StDecode;
         end
         StDecode: begin
            bus.alu_src_b = 2'b11;
            case (bus.opcode)
               6'b100011, 6'b101011: state_d = StMemAdr;
               6'b000000:            state_d = StRtExe;
               6'b000100:            state_d = StBeq;
               6'b001000:            state_d = StAddiExe;
               6'b000010:            state_d = StJump;
               default: begin
                  illegal = 1'b1;
                  state_d = StFetch;
               end
            endcase
         end
         StMemAdr: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'b10;
            state_d       = (bus.opcode == 6'b100011) ? StMemRd : StMemWr;
         end
         StMemRd: begin
            bus.mem_read = 1'b1;
            bus.iord     = 1'b1;
            if (bus.mem_ready) state_d = StMemWb;
         end
         StMemWb: begin
            bus.reg_write  = 1'b1;
            bus.mem_to_reg = 1'b1;
            retire         = 1'b1;
            state_d        = StFetch;
         end
         StMemWr: begin
            bus.mem_write = 1'b1;
            bus.iord      = 1'b1;
            if (bus.mem_ready) begin
               retire  = 1'b1;
               state_d = StFetch;
            end
         end
         StRtExe: begin
            bus.alu_src_a = 1'b1;
            state_d       = StRtWb;
            case (bus.funct)
               6'b100000: bus.aluop = 3'b000;
               6'b100010: bus.aluop = 3'b001;
               6'b100100: bus.aluop = 3'b010;
               6'b100101: bus.aluop = 3'b011;
               6'b101010: bus.aluop = 3'b100;
               6'b100110: bus.aluop = 3'b101;
               default: begin
                  bus.aluop = 3'b111;
                  illegal   = 1'b1;
                  state_d   = StFetch;
               end
            endcase
         end
         StRtWb: begin
            bus.reg_write = 1'b1;
            bus.reg_dst   = 1'b1;
            retire        = 1'b1;
            state_d       = StFetch;
         end
         StBeq: begin
            bus.alu_src_a = 1'b1;
            bus.aluop     = 3'b001;
            bus.pc_src    = 2'b01;
            bus.pc_write  = bus.bcond;
            retire        = 1'b1;
            state_d       = StFetch;
         end
         StAddiExe: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'b10;
            state_d       = StAddiWb;
         end
         StAddiWb: begin
            bus.reg_write = 1'b1;
            retire        = 1'b1;
            state_d       = StFetch;
         end
         StJump: begin
            bus.pc_write = 1'b1;
            bus.pc_src   = 2'b10;
            retire       = 1'b1;
            state_d      = StFetch;
         end
         default: state_d = StFetch;
      endcase
   end

   assign state   = state_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: a vector table walked one clock per row, plus
// hand-written reset and async-reset-mid-instruction sequences.
module tb_mips_mc_ctrl;

   // Control bundle order:
   // {alu_src_a, alu_src_b[1:0], iord, mem_read, mem_write, ir_write, pc_write,
   //  pc_src[1:0], reg_write, reg_dst, mem_to_reg, illegal}
   localparam logic [13:0] CtlFetchWait = 14'b0_01_0_1_0_0_0_00_0_0_0_0;
   localparam logic [13:0] CtlFetchGo   = 14'b0_01_0_1_0_1_1_00_0_0_0_0;
   localparam logic [13:0] CtlDecode    = 14'b0_11_0_0_0_0_0_00_0_0_0_0;
   localparam logic [13:0] CtlDecodeIll = 14'b0_11_0_0_0_0_0_00_0_0_0_1;
   localparam logic [13:0] CtlMemAdr    = 14'b1_10_0_0_0_0_0_00_0_0_0_0;
   localparam logic [13:0] CtlMemRd     = 14'b0_00_1_1_0_0_0_00_0_0_0_0;
   localparam logic [13:0] CtlMemWb     = 14'b0_00_0_0_0_0_0_00_1_0_1_0;
   localparam logic [13:0] CtlMemWr     = 14'b0_00_1_0_1_0_0_00_0_0_0_0;
   localparam logic [13:0] CtlRtExe     = 14'b1_00_0_0_0_0_0_00_0_0_0_0;
   localparam logic [13:0] CtlRtExeIll  = 14'b1_00_0_0_0_0_0_00_0_0_0_1;
   localparam logic [13:0] CtlRtWb      = 14'b0_00_0_0_0_0_0_00_1_1_0_0;
   localparam logic [13:0] CtlBeqTaken  = 14'b1_00_0_0_0_0_1_01_0_0_0_0;
   localparam logic [13:0] CtlBeqNot    = 14'b1_00_0_0_0_0_0_01_0_0_0_0;
   localparam logic [13:0] CtlAddiExe   = 14'b1_10_0_0_0_0_0_00_0_0_0_0;
   localparam logic [13:0] CtlAddiWb    = 14'b0_00_0_0_0_0_0_00_1_0_0_0;
   localparam logic [13:0] CtlJump      = 14'b0_00_0_0_0_0_1_10_0_0_0_0;

   typedef struct {
      logic [5:0]  opcode;
      logic [5:0]  funct;
      logic        bcond;
      logic        mem_ready;
      logic [3:0]  exp_state;
      logic [2:0]  exp_aluop;
      logic [13:0] exp_ctl;
      int unsigned exp_retired;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        illegal;
   logic [3:0]  state;
   logic [31:0] retired;
   logic [13:0] got_ctl;

   vec_t vecs[$];
   int   n_checks;
   int   n_fail;

   mips_mc_ctrl_if bus ();

   mips_mc_ctrl #(
      .RETIRE_W(32)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus    (bus),
      .illegal(illegal),
      .state  (state),
      .retired(retired)
   );

   assign got_ctl = {bus.alu_src_a, bus.alu_src_b, bus.iord, bus.mem_read, bus.mem_write,
                     bus.ir_write, bus.pc_write, bus.pc_src, bus.reg_write, bus.reg_dst,
                     bus.mem_to_reg, illegal};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic push(input logic [5:0] op, input logic [5:0] fn, input logic bc,
                       input logic mr, input logic [3:0] st, input logic [2:0] alu,
                       input logic [13:0] ctl, input int unsigned r);
      vec_t v;
      v.opcode      = op;
      v.funct       = fn;
      v.bcond       = bc;
      v.mem_ready   = mr;
      v.exp_state   = st;
      v.exp_aluop   = alu;
      v.exp_ctl     = ctl;
      v.exp_retired = r;
      vecs.push_back(v);
   endtask

   task automatic rtype(input logic [5:0] fn, input logic [2:0] alu, input int unsigned r);
      push(6'h00, fn, 1'b0, 1'b1, 4'd0, 3'b000, CtlFetchGo, r);
      push(6'h00, fn, 1'b0, 1'b0, 4'd1, 3'b000, CtlDecode,  r);
      push(6'h00, fn, 1'b0, 1'b0, 4'd6, alu,    CtlRtExe,   r);
      push(6'h00, fn, 1'b0, 1'b0, 4'd7, 3'b000, CtlRtWb,    r);
   endtask

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      rst_n         = 1'b0;
      bus.opcode    = 6'h00;
      bus.funct     = 6'h00;
      bus.bcond     = 1'b0;
      bus.mem_ready = 1'b1;

      // FETCH stalls on memory, then six R-type ops covering every funct decode.
      for (int i = 0; i < 3; i++)
         push(6'h00, 6'h00, 1'b0, 1'b0, 4'd0, 3'b000, CtlFetchWait, 0);
      rtype(6'b100000, 3'b000, 0);
      rtype(6'b100010, 3'b001, 1);
      rtype(6'b100100, 3'b010, 2);
      rtype(6'b100101, 3'b011, 3);
      rtype(6'b101010, 3'b100, 4);
      rtype(6'b100110, 3'b101, 5);
      // lw with two memory wait cycles
      push(6'b100011, 6'h00, 1'b0, 1'b1, 4'd0, 3'b000, CtlFetchGo, 6);
      push(6'b100011, 6'h00, 1'b0, 1'b0, 4'd1, 3'b000, CtlDecode,  6);
      push(6'b100011, 6'h00, 1'b0, 1'b0, 4'd2, 3'b000, CtlMemAdr,  6);
      push(6'b100011, 6'h00, 1'b0, 1'b0, 4'd3, 3'b000, CtlMemRd,   6);
      push(6'b100011, 6'h00, 1'b0, 1'b0, 4'd3, 3'b000, CtlMemRd,   6);
      push(6'b100011, 6'h00, 1'b0, 1'b1, 4'd3, 3'b000, CtlMemRd,   6);
      push(6'b100011, 6'h00, 1'b0, 1'b0, 4'd4, 3'b000, CtlMemWb,   6);
      // beq taken, then not taken
      push(6'b000100, 6'h00, 1'b0, 1'b1, 4'd0, 3'b000, CtlFetchGo,  7);
      push(6'b000100, 6'h00, 1'b0, 1'b0, 4'd1, 3'b000, CtlDecode,   7);
      push(6'b000100, 6'h00, 1'b1, 1'b0, 4'd8, 3'b001, CtlBeqTaken, 7);
      push(6'b000100, 6'h00, 1'b0, 1'b1, 4'd0, 3'b000, CtlFetchGo,  8);
      push(6'b000100, 6'h00, 1'b0, 1'b0, 4'd1, 3'b000, CtlDecode,   8);
      push(6'b000100, 6'h00, 1'b0, 1'b0, 4'd8, 3'b001, CtlBeqNot,   8);
      // illegal opcode, then illegal funct: no retire
      push(6'b111111, 6'h00, 1'b0, 1'b1, 4'd0, 3'b000, CtlFetchGo,   9);
      push(6'b111111, 6'h00, 1'b0, 1'b0, 4'd1, 3'b000, CtlDecodeIll, 9);
      push(6'b000000, 6'h01, 1'b0, 1'b1, 4'd0, 3'b000, CtlFetchGo,   9);
      push(6'b000000, 6'h01, 1'b0, 1'b0, 4'd1, 3'b000, CtlDecode,    9);
      push(6'b000000, 6'h01, 1'b0, 1'b0, 4'd6, 3'b111, CtlRtExeIll,  9);
      // sw with one wait cycle
      push(6'b101011, 6'h00, 1'b0, 1'b1, 4'd0, 3'b000, CtlFetchGo, 9);
      push(6'b101011, 6'h00, 1'b0, 1'b0, 4'd1, 3'b000, CtlDecode,  9);
      push(6'b101011, 6'h00, 1'b0, 1'b0, 4'd2, 3'b000, CtlMemAdr,  9);
      push(6'b101011, 6'h00, 1'b0, 1'b0, 4'd5, 3'b000, CtlMemWr,   9);
      push(6'b101011, 6'h00, 1'b0, 1'b1, 4'd5, 3'b000, CtlMemWr,   9);
      // addi
      push(6'b001000, 6'h00, 1'b0, 1'b1, 4'd0,  3'b000, CtlFetchGo, 10);
      push(6'b001000, 6'h00, 1'b0, 1'b0, 4'd1,  3'b000, CtlDecode,  10);
      push(6'b001000, 6'h00, 1'b0, 1'b0, 4'd9,  3'b000, CtlAddiExe, 10);
      push(6'b001000, 6'h00, 1'b0, 1'b0, 4'd10, 3'b000, CtlAddiWb,  10);
      // j
      push(6'b000010, 6'h00, 1'b0, 1'b1, 4'd0,  3'b000, CtlFetchGo,   11);
      push(6'b000010, 6'h00, 1'b0, 1'b0, 4'd1,  3'b000, CtlDecode,    11);
      push(6'b000010, 6'h00, 1'b0, 1'b0, 4'd11, 3'b000, CtlJump,      11);
      push(6'b000010, 6'h00, 1'b0, 1'b0, 4'd0,  3'b000, CtlFetchWait, 12);

      // Reset values, with mem_ready high to show the write strobes stay low.
      #3;
      check("rst_state", 32'(state), 32'd0);
      check("rst_ctl", 32'(got_ctl), 32'(CtlFetchWait));
      check("rst_aluop", 32'(bus.aluop), 32'd0);
      check("rst_retired", retired, 32'd0);
      #9;
      bus.mem_ready = 1'b0;
      rst_n         = 1'b1;

      foreach (vecs[i]) begin
         bus.opcode    = vecs[i].opcode;
         bus.funct     = vecs[i].funct;
         bus.bcond     = vecs[i].bcond;
         bus.mem_ready = vecs[i].mem_ready;
         #1;
         check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
         check($sformatf("vec%0d_aluop", i), 32'(bus.aluop), 32'(vecs[i].exp_aluop));
         check($sformatf("vec%0d_ctl", i), 32'(got_ctl), 32'(vecs[i].exp_ctl));
         check($sformatf("vec%0d_retired", i), retired, vecs[i].exp_retired);
         @(posedge clk);
         #1;
      end

      // sw abandoned by async reset while stalled in MEMWR.
      bus.opcode    = 6'b101011;
      bus.mem_ready = 1'b1;
      @(posedge clk); #1;
      bus.mem_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("memwr_state", 32'(state), 32'd5);
      check("memwr_mem_write", 32'(bus.mem_write), 32'd1);
      #2;
      rst_n         = 1'b0;
      bus.mem_ready = 1'b1;
      #1;
      check("async_state", 32'(state), 32'd0);
      check("async_mem_write", 32'(bus.mem_write), 32'd0);
      check("async_retired", retired, 32'd0);
      check("async_ctl", 32'(got_ctl), 32'(CtlFetchWait));
      #2;
      bus.mem_ready = 1'b0;
      rst_n         = 1'b1;
      @(posedge clk); #1;
      check("release_state", 32'(state), 32'd0);
      check("release_ctl", 32'(got_ctl), 32'(CtlFetchWait));
      bus.mem_ready = 1'b1;
      #1;
      check("release_go_ctl", 32'(got_ctl), 32'(CtlFetchGo));
      @(posedge clk); #1;
      check("release_decode", 32'(state), 32'd1);
      check("release_retired", retired, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
